tx_filt_ctrl: RTL
=================

# tx_filt_ctrl

Sequencer and coefficient manager for the 21-tap symmetric TX pulse-shaping filter. Accepts symbols over a valid/ready handshake, upsamples by zero-stuffing to one filter sample per clock, drains the filter delay line on stop, and owns a double-buffered bank of the 11 unique 0s18 coefficients that is swapped only on symbol boundaries. Sits between the symbol mapper and the filter's `x_in`/coefficient inputs.

## Interface
- `OSR`, 4, samples per symbol (2..16)
- `NUM_COEF`, 11, unique coefficients (symmetric filter, 2*NUM_COEF-1 taps)
- `DATA_W`, 18, sample/coefficient width
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  run request
- `sym_in`  in  DATA_W  signed symbol, 1s17
- `sym_valid`  in  1  symbol available
- `sym_ready`  out  1  symbol accepted this cycle when high with `sym_valid`
- `coef_wr`  in  1  write shadow coefficient
- `coef_addr`  in  4  shadow index 0..NUM_COEF-1 (0 = outer tap, NUM_COEF-1 = centre)
- `coef_data`  in  DATA_W  signed 0s18 coefficient
- `coef_swap`  in  1  request shadow→active copy
- `coef_pend`  out  1  swap requested, not yet applied
- `coef_act`  out  NUM_COEF*DATA_W  active bank, index i at bits [i*DATA_W +: DATA_W]
- `filt_x`  out  DATA_W  registered filter input sample
- `filt_en`  out  1  high while `filt_x` carries a live stream (RUN or FLUSH)
- `underrun`  out  1  sticky: symbol missing at a symbol boundary
- `underrun_clr`  in  1  clears `underrun`
- `state`  out  2  00 IDLE, 01 RUN, 10 FLUSH

## Operation
- FSM IDLE → RUN when `enable`=1; phase counter loads 0.
- RUN: phase counts 0..OSR-1, wraps. `sym_ready` = (state==RUN && phase==0), combinational.
- Phase 0: `filt_x` ← `sym_in` if `sym_valid`, else 0 and `underrun` ← 1. Phases 1..OSR-1: `filt_x` ← 0.
- RUN → FLUSH at the edge where phase==OSR-1 and `enable`=0 (full symbol always completed). `enable` drop mid-symbol has no effect until phase OSR-1.
- FLUSH: emit 2*NUM_COEF-1 (21) zero samples, `sym_ready`=0, then → IDLE. `enable` during FLUSH ignored; re-entry to RUN only from IDLE.
- IDLE: `filt_x`=0, `filt_en`=0, `sym_ready`=0.
- Shadow bank: written on `coef_wr` in any state; `coef_addr` ≥ NUM_COEF ignored. Write to an address is never blocked by a pending swap.
- `coef_swap` sets `coef_pend`. Copy shadow→active occurs at the first edge where state≠RUN, or state==RUN and phase==OSR-1. `coef_pend` clears on that same edge. `coef_swap` and `coef_wr` same cycle: write lands in shadow first, copy includes it only if copy edge is a later cycle.
- `underrun_clr` and a new underrun in the same cycle: set wins.

## Timing
- Reset (async assert, sync release): state IDLE, phase 0, flush count 0, `filt_x`=0, `filt_en`=0, `sym_ready`=0, `underrun`=0, `coef_pend`=0, both banks = reset values (see Configuration).
- Symbol accepted at edge t appears on `filt_x` after edge t (1-cycle latency); followed by OSR-1 zero samples.
- IDLE→RUN: first `sym_ready` in the cycle after `enable` sampled high.
- Stop latency: last symbol sample, OSR-1 zeros, 21 flush zeros, then `filt_en`=0.
- Active bank change visible on `coef_act` the cycle after the copy edge; always aligned so the first sample of a new symbol uses new coefficients.
- Reset mid-FLUSH/RUN: immediate return to IDLE, banks reloaded, no flush.

## Configuration
- `TX_FILT_CTRL_DEFAULT_COEF_EN`: defined → reset loads shadow and active banks with the production RRC set 597, 1226, 829, −1571, −5216, −6849, −2163, 10902, 29429, 45977, 52623 (index 0..10). Undefined → both banks reset to 0 and must be loaded plus swapped before use.

## Test plan
- Reset with macro defined → `coef_act` index 10 = 52623, index 0 = 597; all outputs 0, state 00.
- `enable`=1, `sym_valid`=1, symbols 0x10000, 0x30000 → `filt_x` sequence 0x10000,0,0,0,0x30000,0,0,0; `sym_ready` high every 4th cycle.
- `sym_valid`=0 at phase 0 → `filt_x`=0 that sample, `underrun`=1 and stays 1 until `underrun_clr`.
- `enable` dropped at phase 1 → symbol completes, exactly 21 zero samples with `filt_en`=1, then state IDLE, `filt_en`=0.
- Write shadow idx 10 = 1000, `coef_swap` at phase 1 in RUN → `coef_pend`=1 until phase-3 edge; `coef_act` idx 10 = 1000 from next symbol; write to addr 12 leaves banks unchanged.
- Assert `reset` low mid-FLUSH → state 00, `filt_x`=0 immediately, no further flush samples.

Source files
------------

// File: rtl/tx_filt_ctrl.sv
// tx_filt_ctrl: symbol upsampler, flush sequencer and double-buffered
// coefficient bank for the 21-tap TX shaping filter.
// Build option: TX_FILT_CTRL_DEFAULT_COEF_EN loads the production RRC set at reset.

module tx_filt_ctrl #(
    parameter int OSR      = 4,
    parameter int NUM_COEF = 11,
    parameter int DATA_W   = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [DATA_W-1:0]          sym_in,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic                       coef_wr,
    input  logic [3:0]                 coef_addr,
    input  logic [DATA_W-1:0]          coef_data,
    input  logic                       coef_swap,
    output logic                       coef_pend,
    output logic [NUM_COEF*DATA_W-1:0] coef_act,
    output logic [DATA_W-1:0]          filt_x,
    output logic                       filt_en,
    output logic                       underrun,
    input  logic                       underrun_clr,
    output logic [1:0]                 state
);

    localparam int PH_W = $clog2(OSR);
    localparam int FL_N = 2 * NUM_COEF - 1;
    localparam int FL_W = $clog2(FL_N + 1);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FL_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } st_t;

    st_t               st;
    st_t               st_nxt;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic [FL_W-1:0]   fcnt;
    logic [FL_W-1:0]   fcnt_nxt;
    logic [DATA_W-1:0] shadow [NUM_COEF];
    logic [DATA_W-1:0] active [NUM_COEF];
    logic              copy;
    logic              miss;

    // Reset contents of both coefficient banks.
    function automatic logic [DATA_W-1:0] rst_coef(input int idx);
        int c;
        case (idx)
`ifdef TX_FILT_CTRL_DEFAULT_COEF_EN
            0:  c = 597;
            1:  c = 1226;
            2:  c = 829;
            3:  c = -1571;
            4:  c = -5216;
            5:  c = -6849;
            6:  c = -2163;
            7:  c = 10902;
            8:  c = 29429;
            9:  c = 45977;
            10: c = 52623;
`endif
            default: c = 0;
        endcase
        return DATA_W'(c);
    endfunction

    assign state = st;

    // Bank swap only where it cannot split a symbol: outside RUN or on its last phase.
    assign copy = coef_pend && ((st != ST_RUN) || (phase == PH_LAST));
    assign miss = sym_ready && !sym_valid;

    // State register with symbol-phase and flush counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st    <= ST_IDLE;
            phase <= '0;
            fcnt  <= '0;
        end else begin
            st    <= st_nxt;
            phase <= phase_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // Next-state decode; a stop request only takes effect at the end of a symbol.
    always_comb begin
        st_nxt    = st;
        phase_nxt = phase;
        fcnt_nxt  = fcnt;
        sym_ready = 1'b0;
        unique case (st)
            ST_IDLE: begin
                phase_nxt = '0;
                fcnt_nxt  = '0;
                if (enable) begin
                    st_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                sym_ready = (phase == '0);
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    if (!enable) begin
                        st_nxt = ST_FLUSH;
                    end
                end else begin
                    phase_nxt = phase + 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fcnt == FL_LAST) begin
                    fcnt_nxt = '0;
                    st_nxt   = ST_IDLE;
                end else begin
                    fcnt_nxt = fcnt + 1'b1;
                end
            end
            default: begin
                st_nxt = ST_IDLE;
            end
        endcase
    end

    // Filter sample stream: symbol on phase 0, zero-stuffed otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_x   <= '0;
            filt_en  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            filt_en <= (st != ST_IDLE);
            filt_x  <= (sym_ready && sym_valid) ? sym_in : '0;
            if (miss) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // Shadow writes and shadow-to-active copy; the copy sees pre-edge shadow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_pend <= 1'b0;
            for (int i = 0; i < NUM_COEF; i++) begin
                shadow[i] <= rst_coef(i);
                active[i] <= rst_coef(i);
            end
        end else begin
            coef_pend <= coef_swap | (coef_pend & ~copy);
            for (int i = 0; i < NUM_COEF; i++) begin
                if (coef_wr && (coef_addr == 4'(i))) begin
                    shadow[i] <= coef_data;
                end
                if (copy) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Flatten the active bank for the filter.
    always_comb begin
        coef_act = '0;
        for (int i = 0; i < NUM_COEF; i++) begin
            coef_act[i*DATA_W +: DATA_W] = active[i];
        end
    end

endmodule
